// File: rtl/math_equation_pipe.sv
// math_equation_pipe: three-stage valid/ready pipeline computing
//   q = ((K0 + K1*c) * (a - b) - (d <<< S)) >>> 1
// with runtime K0/K1/S and an optional saturating or wrapping output narrowing.
`timescale 1ns/1ps
module math_equation_pipe #(
  parameter int WIDTH     = 8,
  parameter int CW        = 4,
  parameter int MAX_SHIFT = 7,
  parameter int OUT_W     = 2*WIDTH+CW+2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic signed [WIDTH-1:0]           a,
  input  logic signed [WIDTH-1:0]           b,
  input  logic signed [WIDTH-1:0]           c,
  input  logic signed [WIDTH-1:0]           d,
  input  logic                              cfg_we,
  input  logic signed [CW-1:0]              cfg_k0,
  input  logic signed [CW-1:0]              cfg_k1,
  input  logic [$clog2(MAX_SHIFT+1)-1:0]    cfg_shift,
  input  logic                              cfg_sat,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic signed [OUT_W-1:0]           q,
  output logic                              ovf_o,
  output logic [15:0]                       beat_cnt_o
);

  localparam int QW = 2*WIDTH+CW+2;        // full-precision result width
  localparam int SW = $clog2(MAX_SHIFT+1); // shift-amount width
  localparam int LW = WIDTH+CW+1;          // K0 + K1*c
  localparam int DW = WIDTH+1;             // a - b
  localparam int HW = WIDTH+MAX_SHIFT;     // d <<< S
  localparam int RW = QW+1;                // prod - dsh before the halving

  // Out-of-range shift requests are pinned to the largest legal shift.
  function automatic logic [SW-1:0] clamp_shift(input logic [SW-1:0] s);
    if (int'(s) > MAX_SHIFT) return SW'(MAX_SHIFT);
    return s;
  endfunction

  // Narrow a QW-bit result to OUT_W bits; returns {ovf, value}.
  // The value fits when every bit from the OUT_W sign bit upward agrees.
  function automatic logic [OUT_W:0] narrow(input logic signed [QW-1:0] r,
                                            input logic               sat);
    logic [QW-OUT_W:0] top;
    logic              fits;
    logic [OUT_W-1:0]  res;
    top  = r[QW-1:OUT_W-1];
    fits = (&top) | ~(|top);
    if (fits || !sat) res = r[OUT_W-1:0];
    else if (r[QW-1]) res = {1'b1, {(OUT_W-1){1'b0}}};
    else              res = {1'b0, {(OUT_W-1){1'b1}}};
    return {~fits, res};
  endfunction

  logic signed [CW-1:0] k0_r, k1_r;
  logic [SW-1:0]        shift_r;
  logic                 sat_r;

  logic                 vld_p0, vld_p1;
  logic                 en_p0, en_p1, en_p2;
  logic                 acc;

  logic signed [LW-1:0] lin_w, lin_p0;
  logic signed [DW-1:0] diff_w, diff_p0;
  logic signed [HW-1:0] dsh_w, dsh_p0, dsh_p1;
  logic                 sat_p0, sat_p1;
  logic signed [QW-1:0] prod_w, prod_p1;
  logic signed [RW-1:0] sum_w;
  logic signed [QW-1:0] r_w;
  logic [OUT_W:0]       nar_w;

  // A stage may load when it is empty or its occupant moves on this cycle.
  assign en_p2   = !valid_o || ready_i;
  assign en_p1   = !vld_p1 || en_p2;
  assign en_p0   = !vld_p0 || en_p1;
  assign ready_o = en_p0;
  assign acc     = valid_i && en_p0;

  // Stage 0 arithmetic
  assign lin_w  = LW'(k0_r) + LW'(k1_r) * LW'(c);
  assign diff_w = DW'(a) - DW'(b);
  assign dsh_w  = HW'(d) <<< shift_r;

  // Stage 1 arithmetic
  assign prod_w = QW'(lin_p0) * QW'(diff_p0);

  // Stage 2 arithmetic: dropping the LSB of the QW+1-bit difference is the
  // floor-toward-minus-infinity halving.
  assign sum_w = RW'(prod_p1) - RW'(dsh_p1);
  assign r_w   = sum_w[RW-1:1];
  assign nar_w = narrow(r_w, sat_p1);

  // Configuration registers; a write is seen by beats accepted from the next cycle on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k0_r    <= CW'(1);
      k1_r    <= CW'(3);
      shift_r <= SW'(2);
      sat_r   <= 1'b1;
    end else if (cfg_we) begin
      k0_r    <= cfg_k0;
      k1_r    <= cfg_k1;
      shift_r <= clamp_shift(cfg_shift);
      sat_r   <= cfg_sat;
    end
  end

  // Stage occupancy and delivered-beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      valid_o    <= 1'b0;
      beat_cnt_o <= 16'd0;
    end else begin
      if (en_p0) vld_p0 <= valid_i;
      if (en_p1) vld_p1 <= vld_p0;
      if (en_p2) valid_o <= vld_p1;
      if (valid_o && ready_i) beat_cnt_o <= beat_cnt_o + 16'd1;
    end
  end

  // Stage 0 / stage 1 boundary: intermediate data, no reset needed.
  always_ff @(posedge clk) begin
    if (acc) begin
      lin_p0  <= lin_w;
      diff_p0 <= diff_w;
      dsh_p0  <= dsh_w;
      sat_p0  <= sat_r;
    end
    if (en_p1 && vld_p0) begin
      prod_p1 <= prod_w;
      dsh_p1  <= dsh_p0;
      sat_p1  <= sat_p0;
    end
  end

  // Stage 2 / output register: held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      ovf_o <= 1'b0;
    end else if (en_p2 && vld_p1) begin
      ovf_o <= nar_w[OUT_W];
      q     <= nar_w[OUT_W-1:0];
    end
  end

endmodule

// File: tb/tb_math_equation_pipe.sv
// Scoreboard bench for math_equation_pipe: a full-width instance and a
// 16-bit narrowed instance share stimulus; expected results come from a
// plain-arithmetic model of the equation.
`timescale 1ns/1ps
module tb_math_equation_pipe;
  localparam int WIDTH = 8, CW = 4, MAX_SHIFT = 7, SW = 3;
  localparam int QW = 2*WIDTH+CW+2, NW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic valid_i = 1'b0, ready_i = 1'b1, cfg_we = 1'b0, cfg_sat = 1'b1;
  logic signed [WIDTH-1:0] a = '0, b = '0, c = '0, d = '0;
  logic signed [CW-1:0] cfg_k0 = '0, cfg_k1 = '0;
  logic [SW-1:0] cfg_shift = '0;

  logic ready_o_w, valid_o_w, ovf_w;
  logic signed [QW-1:0] q_w;
  logic [15:0] bc_w;
  logic ready_o_n, valid_o_n, ovf_n;
  logic signed [NW-1:0] q_n;
  logic [15:0] bc_n;

  math_equation_pipe #(.WIDTH(WIDTH), .CW(CW), .MAX_SHIFT(MAX_SHIFT), .OUT_W(QW)) u_wide (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o_w),
    .a(a), .b(b), .c(c), .d(d), .cfg_we(cfg_we), .cfg_k0(cfg_k0), .cfg_k1(cfg_k1),
    .cfg_shift(cfg_shift), .cfg_sat(cfg_sat), .valid_o(valid_o_w), .ready_i(ready_i),
    .q(q_w), .ovf_o(ovf_w), .beat_cnt_o(bc_w));

  math_equation_pipe #(.WIDTH(WIDTH), .CW(CW), .MAX_SHIFT(MAX_SHIFT), .OUT_W(NW)) u_narrow (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o_n),
    .a(a), .b(b), .c(c), .d(d), .cfg_we(cfg_we), .cfg_k0(cfg_k0), .cfg_k1(cfg_k1),
    .cfg_shift(cfg_shift), .cfg_sat(cfg_sat), .valid_o(valid_o_n), .ready_i(ready_i),
    .q(q_n), .ovf_o(ovf_n), .beat_cnt_o(bc_n));

  typedef struct { longint q; bit ovf; } exp_t;
  exp_t sb_w[$];
  exp_t sb_n[$];

  int k0_m = 1, k1_m = 3, s_m = 2;
  bit sat_m = 1'b1;
  int checks = 0, failures = 0;
  int delivered_w = 0, delivered_n = 0, n_acc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Exact value of the equation, halved with floor.
  function automatic longint ref_val(input longint av, bv, cv, dv, k0, k1, s);
    longint full;
    full = (k0 + k1 * cv) * (av - bv) - dv * (longint'(1) << s);
    return full >>> 1;
  endfunction

  function automatic exp_t narrow_ref(input longint r, input bit sat);
    exp_t e;
    longint hi, lo, span, m;
    hi = (longint'(1) << (NW-1)) - 1;
    lo = -hi - 1;
    span = longint'(1) << NW;
    if (r >= lo && r <= hi) begin
      e.q = r; e.ovf = 1'b0;
    end else begin
      e.ovf = 1'b1;
      if (sat) e.q = (r > hi) ? hi : lo;
      else begin
        m = (r - lo) % span;
        if (m < 0) m += span;
        e.q = m + lo;
      end
    end
    return e;
  endfunction

  // Input side: record the expected result of every accepted beat.
  always @(negedge clk) begin
    longint r;
    if (rst_n) begin
      if (valid_i && ready_o_w) begin
        r = ref_val(a, b, c, d, k0_m, k1_m, s_m);
        sb_w.push_back('{r, 1'b0});
        n_acc++;
      end
      if (valid_i && ready_o_n) begin
        r = ref_val(a, b, c, d, k0_m, k1_m, s_m);
        sb_n.push_back(narrow_ref(r, sat_m));
      end
      if (cfg_we) begin
        k0_m = cfg_k0; k1_m = cfg_k1; sat_m = cfg_sat;
        s_m = (int'(cfg_shift) > MAX_SHIFT) ? MAX_SHIFT : int'(cfg_shift);
      end
    end
  end

  // Output side: compare every delivered beat and the delivery counter.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("beat_cnt_w", bc_w, delivered_w % 65536);
      chk("beat_cnt_n", bc_n, delivered_n % 65536);
      if (valid_o_w && ready_i) begin
        if (sb_w.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_w_unexpected: got q=%0d with nothing expected", q_w);
        end else begin
          e = sb_w.pop_front();
          chk("q_w", q_w, e.q);
          chk("ovf_w", ovf_w, e.ovf);
        end
        delivered_w++;
      end
      if (valid_o_n && ready_i) begin
        if (sb_n.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_n_unexpected: got q=%0d with nothing expected", q_n);
        end else begin
          e = sb_n.pop_front();
          chk("q_n", q_n, e.q);
          chk("ovf_n", ovf_n, e.ovf);
        end
        delivered_n++;
      end
    end
  end

  task automatic do_reset();
    valid_i = 1'b0; cfg_we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid_o_w", valid_o_w, 0);
    chk("rst_valid_o_n", valid_o_n, 0);
    chk("rst_beat_cnt", bc_w, 0);
    chk("rst_q", q_w, 0);
    chk("rst_ovf", ovf_n, 0);
    sb_w.delete(); sb_n.delete();
    delivered_w = 0; delivered_n = 0;
    k0_m = 1; k1_m = 3; s_m = 2; sat_m = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ready_after_rst", ready_o_w, 1);
  endtask

  // Present one beat (called at posedge+1) and hold it until accepted.
  task automatic send(input logic signed [WIDTH-1:0] av, bv, cv, dv);
    int n = 0;
    bit taken = 1'b0;
    a = av; b = bv; c = cv; d = dv; valid_i = 1'b1;
    do begin
      @(negedge clk); taken = ready_o_w;
      @(posedge clk); #1; n++;
    end while (!taken && n < 100);
    if (!taken) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
    valid_i = 1'b0; cfg_we = 1'b0;
  endtask

  // Wait for the next delivered beat and check it against fixed values.
  task automatic expect_next(input string name, input longint qw_e, input longint qn_e, input bit ovfn_e);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (valid_o_w && ready_i) begin
        seen = 1'b1;
        chk({name, "_qw"}, q_w, qw_e);
        chk({name, "_qn"}, q_n, qn_e);
        chk({name, "_ovfn"}, ovf_n, ovfn_e);
      end
      @(posedge clk); #1; n++;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no output expected one within 20 cycles", name);
    end
  endtask

  initial begin
    int accepts;
    int target, cyc;
    bit did_rst;
    logic [15:0] bc0;

    #2 do_reset();
    @(posedge clk); #1;

    // Default config, first beat and its latency.
    ready_i = 1'b1;
    a = 8'sd5; b = 8'sd2; c = 8'sd4; d = 8'sd3; valid_i = 1'b1;
    @(posedge clk); #1 valid_i = 1'b0;
    chk("lat_edge1", valid_o_w, 0);
    @(posedge clk); #1 chk("lat_edge2", valid_o_w, 0);
    @(posedge clk); #1;
    chk("lat_edge3", valid_o_w, 1);
    chk("basic_q", q_w, 13);
    chk("basic_ovf", ovf_w, 0);
    @(posedge clk); #1 chk("basic_cnt", bc_w, 1);

    // Extreme operands and floor rounding.
    send(-8'sd128, 8'sd127, -8'sd128, -8'sd128);
    send(8'sd0, 8'sd1, 8'sd0, 8'sd0);
    expect_next("extreme_sat", 49088, 32767, 1'b1);
    expect_next("floor", -1, -1, 1'b0);

    // Wrap mode on the narrowed instance.
    cfg_we = 1'b1; cfg_k0 = 4'sd1; cfg_k1 = 4'sd3; cfg_shift = 3'd2; cfg_sat = 1'b0;
    @(posedge clk); #1 cfg_we = 1'b0;
    send(-8'sd128, 8'sd127, -8'sd128, -8'sd128);
    expect_next("extreme_wrap", 49088, -16448, 1'b1);

    // Config write in the same cycle as a beat.
    cfg_we = 1'b1; cfg_k0 = 4'sd0; cfg_k1 = 4'sd1; cfg_shift = 3'd0; cfg_sat = 1'b1;
    send(8'sd5, 8'sd2, 8'sd4, 8'sd3);
    send(8'sd5, 8'sd2, 8'sd4, 8'sd3);
    expect_next("cfg_old", 13, 13, 1'b0);
    expect_next("cfg_new", 4, 4, 1'b0);

    // Back-pressure: capacity, held output, combinational ready path.
    repeat (5) @(posedge clk);
    #1;
    ready_i = 1'b0; valid_i = 1'b1;
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      @(negedge clk); if (ready_o_w) accepts++;
      @(posedge clk); #1;
    end
    chk("stall_accepts", accepts, 3);
    chk("stall_ready_o", ready_o_w, 0);
    chk("stall_valid_o", valid_o_w, 1);
    if (sb_w.size() > 0) chk("stall_q_head", q_w, sb_w[0].q);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_valid_hold", valid_o_w, 1);
    if (sb_w.size() > 0) chk("stall_q_hold", q_w, sb_w[0].q);
    bc0 = bc_w;
    valid_i = 1'b0; ready_i = 1'b1;
    #1 chk("stall_ready_follows", ready_o_w, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_cnt_plus3", bc_w, (int'(bc0) + 3) % 65536);
    send(8'sd7, -8'sd3, 8'sd2, 8'sd1);

    // Randomized stream with one reset in the middle.
    target = n_acc + 10000;
    cyc = 0;
    did_rst = 1'b0;
    while (n_acc < target && cyc < 60000) begin
      @(posedge clk); #1; cyc++;
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 7);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      cfg_we = ($urandom_range(0, 99) == 0);
      cfg_k0 = 4'($urandom); cfg_k1 = 4'($urandom);
      cfg_shift = 3'($urandom); cfg_sat = 1'($urandom);
      if (!did_rst && n_acc >= target - 5000) begin
        did_rst = 1'b1;
        do_reset();
      end
    end
    if (n_acc < target) begin
      checks++; failures++;
      $display("FAIL random_budget: got %0d accepts expected %0d", n_acc, target);
    end

    // Drain and confirm nothing is left outstanding.
    valid_i = 1'b0; cfg_we = 1'b0; ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_w", sb_w.size(), 0);
    chk("drain_n", sb_n.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
